// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the load/store unit.
// Memory op codes, FSM states, access sizes and the byte-lane functions live here.
package lsu_pkg;

    localparam int DATA_W           = 32;
    localparam int DBUS_TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        RD_NONE = 3'd0,
        RD_LB   = 3'd1,
        RD_LH   = 3'd2,
        RD_LW   = 3'd3,
        RD_LBU  = 3'd4,
        RD_LHU  = 3'd5
    } mem_rd_op_e;

    typedef enum logic [1:0] {
        WR_NONE = 2'd0,
        WR_SB   = 2'd1,
        WR_SH   = 2'd2,
        WR_SW   = 2'd3
    } mem_wr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    function automatic logic rd_op_valid(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd5);
    endfunction

    // Loads win over stores when both op fields are set.
    function automatic acc_size_e op_size(input logic is_load, input logic [2:0] rd_op,
                                          input logic [1:0] wr_op);
        acc_size_e sz;
        sz = SZ_WORD;
        if (is_load) begin
            case (rd_op)
                RD_LB, RD_LBU: sz = SZ_BYTE;
                RD_LH, RD_LHU: sz = SZ_HALF;
                default:       sz = SZ_WORD;
            endcase
        end else begin
            case (wr_op)
                WR_SB:   sz = SZ_BYTE;
                WR_SH:   sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    function automatic logic [3:0] lane_be(input acc_size_e sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input acc_size_e sz, input logic [31:0] wdata);
        logic [31:0] d;
        case (sz)
            SZ_BYTE: d = {4{wdata[7:0]}};
            SZ_HALF: d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Combinational load formatter: picks the addressed byte/half out of the bus word
// and sign- or zero-extends it according to the load op.
module lsu_load_fmt
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  rd_op,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select and extension
    always_comb begin
        byte_s = rdata[{off, 3'b000} +: 8];
        half_s = off[1] ? rdata[31:16] : rdata[15:0];
        case (rd_op)
            RD_LB:   data = {{24{byte_s[7]}}, byte_s};
            RD_LBU:  data = {24'h000000, byte_s};
            RD_LH:   data = {{16{half_s[15]}}, half_s};
            RD_LHU:  data = {16'h0000, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit at the EX->MEM boundary: one req/gnt/rvalid bus transaction per
// memory op, stalling the pipeline until it completes, times out or is found misaligned.
module lsu
    import lsu_pkg::*;
#(
    parameter int DBUS_TIMEOUT = DBUS_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [2:0]  ex_mem_rd_op,
    input  logic [1:0]  ex_mem_wr_op,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        lsu_mem_rd,
    output logic        lsu_stall,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic [31:0] mem2wb_load_data,
    output logic        mem2wb_load_vld,
    output logic        lsu_misaligned,
    output logic        lsu_bus_err
);

    localparam int CNT_W = (DBUS_TIMEOUT > 1) ? $clog2(DBUS_TIMEOUT + 1) : 1;

    lsu_state_e       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       off_r;
    logic [2:0]       rd_op_r;
    logic             is_load_r;

    logic             load_sel_s, op_any_s, misaligned_s, accept_s;
    logic             timeout_s, abort_s, load_done_s;
    acc_size_e        size_s;
    logic [31:0]      fmt_data_s;

    // Decode of the EX-stage op and transaction events
    always_comb begin
        load_sel_s   = rd_op_valid(ex_mem_rd_op);
        op_any_s     = load_sel_s | (ex_mem_wr_op != 2'd0);
        size_s       = op_size(load_sel_s, ex_mem_rd_op, ex_mem_wr_op);
        misaligned_s = ((size_s == SZ_HALF) & ex_addr[0]) |
                       ((size_s == SZ_WORD) & (ex_addr[1:0] != 2'b00));
        accept_s     = (state_r == ST_IDLE) & ex_valid & op_any_s & ~misaligned_s;
        timeout_s    = (DBUS_TIMEOUT != 0) && (cnt_r == CNT_W'(DBUS_TIMEOUT - 1));
        abort_s      = timeout_s & (((state_r == ST_REQ) & ~dbus_gnt) |
                                    ((state_r == ST_RESP) & ~dbus_rvalid));
        // A zero-wait slave may return data in the grant cycle.
        load_done_s  = ((state_r == ST_RESP) & dbus_rvalid) |
                       ((state_r == ST_REQ) & dbus_gnt & dbus_rvalid & is_load_r);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nxt_s;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_REQ;
                else          state_nxt_s = ST_IDLE;
            end
            ST_REQ: begin
                if (dbus_gnt) state_nxt_s = (~is_load_r | dbus_rvalid) ? ST_IDLE : ST_RESP;
                else if (timeout_s) state_nxt_s = ST_IDLE;
                else                state_nxt_s = ST_REQ;
            end
            ST_RESP: begin
                if (dbus_rvalid | timeout_s) state_nxt_s = ST_IDLE;
                else                         state_nxt_s = ST_RESP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM combinational outputs
    always_comb begin
        lsu_mem_rd = ex_valid & load_sel_s;
        lsu_stall  = accept_s | (state_r == ST_REQ) | ((state_r == ST_RESP) & ~dbus_rvalid);
    end

    // Wait counter, restarted whenever a REQ or RESP phase begins
    always_ff @(posedge clk) begin
        if (rst || (state_nxt_s != state_r) || (state_r == ST_IDLE)) cnt_r <= '0;
        else                                                        cnt_r <= cnt_r + CNT_W'(1);
    end

    lsu_load_fmt u_fmt (
        .rdata (dbus_rdata),
        .off   (off_r),
        .rd_op (rd_op_r),
        .data  (fmt_data_s)
    );

    // Bus request registers, load result and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            dbus_req         <= 1'b0;
            dbus_we          <= 1'b0;
            dbus_addr        <= 32'h0000_0000;
            dbus_wdata       <= 32'h0000_0000;
            dbus_be          <= 4'h0;
            off_r            <= 2'b00;
            rd_op_r          <= 3'd0;
            is_load_r        <= 1'b0;
            mem2wb_load_data <= 32'h0000_0000;
            mem2wb_load_vld  <= 1'b0;
            lsu_misaligned   <= 1'b0;
            lsu_bus_err      <= 1'b0;
        end else begin
            lsu_misaligned  <= (state_r == ST_IDLE) & ex_valid & op_any_s & misaligned_s;
            mem2wb_load_vld <= load_done_s;
            lsu_bus_err     <= abort_s;
            if (accept_s) begin
                dbus_req   <= 1'b1;
                dbus_we    <= ~load_sel_s;
                dbus_addr  <= {ex_addr[31:2], 2'b00};
                dbus_wdata <= lane_wdata(size_s, ex_wdata);
                dbus_be    <= lane_be(size_s, ex_addr[1:0]);
                off_r      <= ex_addr[1:0];
                rd_op_r    <= ex_mem_rd_op;
                is_load_r  <= load_sel_s;
            end else if (((state_r == ST_REQ) & dbus_gnt) | abort_s) begin
                dbus_req <= 1'b0;
            end
            if (load_done_s) mem2wb_load_data <= fmt_data_s;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads, stores, misalignment, timeout and reset mid-transaction.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [2:0]  ex_mem_rd_op;
    logic [1:0]  ex_mem_wr_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        lsu_mem_rd;
    logic        lsu_stall;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic [31:0] mem2wb_load_data;
    logic        mem2wb_load_vld;
    logic        lsu_misaligned;
    logic        lsu_bus_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu #(.DBUS_TIMEOUT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_mem_rd_op     (ex_mem_rd_op),
        .ex_mem_wr_op     (ex_mem_wr_op),
        .ex_addr          (ex_addr),
        .ex_wdata         (ex_wdata),
        .lsu_mem_rd       (lsu_mem_rd),
        .lsu_stall        (lsu_stall),
        .dbus_req         (dbus_req),
        .dbus_we          (dbus_we),
        .dbus_addr        (dbus_addr),
        .dbus_wdata       (dbus_wdata),
        .dbus_be          (dbus_be),
        .dbus_gnt         (dbus_gnt),
        .dbus_rvalid      (dbus_rvalid),
        .dbus_rdata       (dbus_rdata),
        .mem2wb_load_data (mem2wb_load_data),
        .mem2wb_load_vld  (mem2wb_load_vld),
        .lsu_misaligned   (lsu_misaligned),
        .lsu_bus_err      (lsu_bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load with gw REQ wait cycles before gnt and rvalid rw cycles after gnt (0 = same cycle).
    task automatic load_txn(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] rdata, input int gw, input int rw,
                            input logic [3:0] exp_be, input logic [31:0] exp_data);
        ex_valid = 1'b1; ex_mem_rd_op = op; ex_addr = addr;
        #1 chk({tag, "/stall_acc"}, lsu_stall, 1'b1);
        chk({tag, "/mem_rd"}, lsu_mem_rd, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_rd_op = 3'd0; ex_mem_wr_op = 2'd0;
        repeat (gw) begin
            #1 chk({tag, "/req_wait"}, dbus_req, 1'b1);
            chk({tag, "/stall_req"}, lsu_stall, 1'b1);
            @(negedge clk);
        end
        dbus_gnt = 1'b1;
        if (rw == 0) begin dbus_rvalid = 1'b1; dbus_rdata = rdata; end
        #1 chk({tag, "/req"}, dbus_req, 1'b1);
        chk({tag, "/we"}, dbus_we, 1'b0);
        chk({tag, "/be"}, dbus_be, exp_be);
        chk({tag, "/addr"}, dbus_addr, {addr[31:2], 2'b00});
        @(negedge clk);
        dbus_gnt = 1'b0;
        if (rw > 0) begin
            repeat (rw - 1) begin
                #1 chk({tag, "/stall_resp"}, lsu_stall, 1'b1);
                chk({tag, "/req_drop"}, dbus_req, 1'b0);
                @(negedge clk);
            end
            dbus_rvalid = 1'b1; dbus_rdata = rdata;
            #1 chk({tag, "/stall_rv"}, lsu_stall, 1'b0);
            chk({tag, "/vld_early"}, mem2wb_load_vld, 1'b0);
            @(negedge clk);
        end
        dbus_rvalid = 1'b0;
        #1 chk({tag, "/vld"}, mem2wb_load_vld, 1'b1);
        chk({tag, "/data"}, mem2wb_load_data, exp_data);
        @(negedge clk);
        #1 chk({tag, "/vld_pulse"}, mem2wb_load_vld, 1'b0);
        @(negedge clk);
    endtask

    // Store granted in its first request cycle.
    task automatic store_txn(input string tag, input logic [1:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata);
        ex_valid = 1'b1; ex_mem_wr_op = op; ex_addr = addr; ex_wdata = wdata;
        #1 chk({tag, "/stall_acc"}, lsu_stall, 1'b1);
        chk({tag, "/mem_rd"}, lsu_mem_rd, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_wr_op = 2'd0;
        dbus_gnt = 1'b1;
        #1 chk({tag, "/req"}, dbus_req, 1'b1);
        chk({tag, "/we"}, dbus_we, 1'b1);
        chk({tag, "/be"}, dbus_be, exp_be);
        chk({tag, "/wdata"}, dbus_wdata, exp_wdata);
        chk({tag, "/addr"}, dbus_addr, {addr[31:2], 2'b00});
        @(negedge clk);
        dbus_gnt = 1'b0;
        #1 chk({tag, "/req_done"}, dbus_req, 1'b0);
        chk({tag, "/stall_done"}, lsu_stall, 1'b0);
        chk({tag, "/no_vld"}, mem2wb_load_vld, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_mem_rd_op = 3'd0; ex_mem_wr_op = 2'd0;
        ex_addr = 32'h0; ex_wdata = 32'h0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
        dbus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1 chk("rst/req", dbus_req, 1'b0);
        chk("rst/we", dbus_we, 1'b0);
        chk("rst/be", dbus_be, 4'h0);
        chk("rst/addr", dbus_addr, 32'h0);
        chk("rst/wdata", dbus_wdata, 32'h0);
        chk("rst/ldata", mem2wb_load_data, 32'h0);
        chk("rst/vld", mem2wb_load_vld, 1'b0);
        chk("rst/mis", lsu_misaligned, 1'b0);
        chk("rst/err", lsu_bus_err, 1'b0);
        chk("rst/stall", lsu_stall, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // LW: gnt after one wait cycle, rvalid two cycles after gnt -> 4 stall cycles
        load_txn("lw", 3'd3, 32'h0000_0100, 32'hDEAD_BEEF, 1, 2, 4'hF, 32'hDEAD_BEEF);
        // Byte/half formatting, including zero-wait slave responses
        load_txn("lb", 3'd1, 32'h0000_0103, 32'h8011_2233, 0, 1, 4'b1000, 32'hFFFF_FF80);
        load_txn("lbu", 3'd4, 32'h0000_0103, 32'h8011_2233, 0, 0, 4'b1000, 32'h0000_0080);
        load_txn("lhu", 3'd5, 32'h0000_0102, 32'h8011_2233, 0, 1, 4'b1100, 32'h0000_8011);
        load_txn("lh", 3'd2, 32'h0000_0102, 32'h8011_2233, 0, 0, 4'b1100, 32'hFFFF_8011);
        load_txn("lb0", 3'd1, 32'h0000_0100, 32'h8011_22B3, 0, 1, 4'b0001, 32'hFFFF_FFB3);
        // Load wins when a store op is also present (SW at 0x101 alone would be misaligned)
        ex_mem_wr_op = 2'd3;
        load_txn("prio", 3'd4, 32'h0000_0101, 32'h8011_2233, 0, 1, 4'b0010, 32'h0000_0022);

        store_txn("sb", 2'd1, 32'h0000_0101, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
        store_txn("sh", 2'd2, 32'h0000_0102, 32'h1234_CDEF, 4'b1100, 32'hCDEF_CDEF);
        store_txn("sw", 2'd3, 32'h0000_0104, 32'h1234_CDEF, 4'hF, 32'h1234_CDEF);

        // Misaligned LW: single pulse, no request, no stall
        ex_valid = 1'b1; ex_mem_rd_op = 3'd3; ex_addr = 32'h0000_0102;
        #1 chk("mis/stall", lsu_stall, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_rd_op = 3'd0;
        #1 chk("mis/pulse", lsu_misaligned, 1'b1);
        chk("mis/req", dbus_req, 1'b0);
        chk("mis/stall2", lsu_stall, 1'b0);
        @(negedge clk);
        #1 chk("mis/pulse_end", lsu_misaligned, 1'b0);
        chk("mis/req2", dbus_req, 1'b0);
        @(negedge clk);

        // Timeout: no grant, request held for 4 cycles then aborted
        ex_valid = 1'b1; ex_mem_rd_op = 3'd3; ex_addr = 32'h0000_0200;
        #1 chk("to/stall_acc", lsu_stall, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_rd_op = 3'd0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("to/req", dbus_req, 1'b1);
            chk("to/stall", lsu_stall, 1'b1);
            @(negedge clk);
        end
        #1 chk("to/req_drop", dbus_req, 1'b0);
        chk("to/err", lsu_bus_err, 1'b1);
        chk("to/stall_rel", lsu_stall, 1'b0);
        chk("to/no_vld", mem2wb_load_vld, 1'b0);
        @(negedge clk);
        #1 chk("to/err_pulse", lsu_bus_err, 1'b0);
        @(negedge clk);

        // Reset while waiting in RESP, then a late rvalid
        ex_valid = 1'b1; ex_mem_rd_op = 3'd3; ex_addr = 32'h0000_0300;
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_rd_op = 3'd0; dbus_gnt = 1'b1;
        @(negedge clk);
        dbus_gnt = 1'b0; rst = 1'b1;
        #1 chk("rr/stall_resp", lsu_stall, 1'b1);
        @(negedge clk);
        rst = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h1234_5678;
        #1 chk("rr/req", dbus_req, 1'b0);
        chk("rr/stall", lsu_stall, 1'b0);
        chk("rr/vld", mem2wb_load_vld, 1'b0);
        @(negedge clk);
        dbus_rvalid = 1'b0;
        #1 chk("rr/vld_late", mem2wb_load_vld, 1'b0);
        chk("rr/data", mem2wb_load_data, 32'h0);
        @(negedge clk);
        load_txn("rr_lw", 3'd3, 32'h0000_0304, 32'hCAFE_F00D, 1, 1, 4'hF, 32'hCAFE_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
